// File: rtl/ltc_pkg.sv
// Shared definitions for the LTC generator timing scheduler: rate codes,
// scheduler states, frame geometry and increment-field indices.
package ltc_pkg;

  typedef enum logic [1:0] {
    RATE_24  = 2'b00,
    RATE_25  = 2'b01,
    RATE_BAD = 2'b10,
    RATE_30  = 2'b11
  } rate_e;

  typedef enum logic [1:0] {
    STOP,
    ARM,
    RUN,
    STOPPING
  } state_e;

  localparam int HALVES = 160;
  localparam int IDX_W  = 8;
  localparam int DIV_W  = 12;

  localparam int SEC = 0;
  localparam int MIN = 1;
  localparam int HRS = 2;

  // Terminal count (divide ratio minus one) for a latched, valid rate.
  function automatic logic [DIV_W-1:0] rate_tc(rate_e r, int d24, int d25, int d30);
    case (r)
      RATE_25: rate_tc = DIV_W'(d25 - 1);
      RATE_30: rate_tc = DIV_W'(d30 - 1);
      default: rate_tc = DIV_W'(d24 - 1);
    endcase
  endfunction

endpackage

// File: rtl/ltc_sched_if.sv
// Scheduler <-> datapath bundle: jam/increment requests in, update strobes
// and half-bit position out. The scheduler takes the slave side.
interface ltc_sched_if;
  logic       jam_valid;
  logic       jam_ready;
  logic [2:0] inc_req;
  logic [2:0] inc_grant;
  logic       load_stb;
  logic       frame_stb;
  logic       half_stb;
  logic [7:0] half_idx;

  modport master (
    output jam_valid, inc_req,
    input  jam_ready, inc_grant, load_stb, frame_stb, half_stb, half_idx
  );

  modport slave (
    input  jam_valid, inc_req,
    output jam_ready, inc_grant, load_stb, frame_stb, half_stb, half_idx
  );
endinterface

// File: rtl/ltc_half_div.sv
// Programmable half-bit divider: counts 0..tc while enabled, pulses tick on
// the terminal count and restarts; clr forces the count back to zero.
module ltc_half_div
  import ltc_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] tc,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == tc);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ltc_sched.sv
// LTC timing scheduler and update arbiter: half-bit/frame strobes, run/stop
// sequencing, and one-update-per-cycle arbitration of jam, frame and increments.
// Optional frame_cnt output enabled by defining LTC_SCHED_FRAMECNT_EN.
module ltc_sched
  import ltc_pkg::*;
#(
  parameter int DIV_24 = 3125,
  parameter int DIV_25 = 3000,
  parameter int DIV_30 = 2500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  framerate,
  input  logic        run,
  ltc_sched_if.slave  bus,
  output logic        running,
  output logic        rate_err
`ifdef LTC_SCHED_FRAMECNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  state_e           state_q, state_d;
  rate_e            rate_q, rate_d;
  logic [IDX_W-1:0] half_idx_q, half_idx_d;
  logic             half_stb_q, half_stb_d;
  logic             frame_stb_q, frame_stb_d;
  logic             load_stb_q, load_stb_d;
  logic             rate_err_q, rate_err_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       grant_q, grant_d;

  logic             counting;
  logic             tick;
  logic             wrap;
  logic             jam_ok;
  rate_e            fr_in;
  logic [DIV_W-1:0] tc;

  assign fr_in    = rate_e'(framerate);
  assign counting = (state_q == RUN) || (state_q == STOPPING);
  assign tc       = rate_tc(rate_q, DIV_24, DIV_25, DIV_30);
  assign wrap     = tick && (half_idx_q == IDX_W'(HALVES - 1));

  ltc_half_div u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!counting),
    .en      (counting),
    .tc      (tc),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    rate_err_d  = rate_err_q;
    half_idx_d  = half_idx_q;
    half_stb_d  = tick;
    frame_stb_d = 1'b0;
    load_stb_d  = 1'b0;
    jam_ok      = 1'b0;
    grant_d     = '0;

    if (tick) half_idx_d = wrap ? '0 : half_idx_q + 1'b1;

    case (state_q)
      STOP: begin
        half_idx_d = '0;
        rate_err_d = 1'b0;
        jam_ok     = 1'b1;
        if (run) state_d = ARM;
      end
      ARM: begin
        jam_ok = 1'b1;
        if (!run) begin
          state_d = STOP;
        end else if (fr_in == RATE_BAD) begin
          rate_err_d = 1'b1;
        end else begin
          rate_d      = fr_in;
          rate_err_d  = 1'b0;
          state_d     = RUN;
          frame_stb_d = 1'b1;
        end
      end
      RUN: begin
        // A bad code at the boundary keeps the old rate but is still flagged.
        if (wrap) begin
          frame_stb_d = 1'b1;
          jam_ok      = 1'b1;
          if (fr_in == RATE_BAD) begin
            rate_err_d = 1'b1;
          end else begin
            rate_d     = fr_in;
            rate_err_d = 1'b0;
          end
        end
        if (!run) state_d = STOPPING;
      end
      STOPPING: begin
        if (run)       state_d = RUN;
        else if (wrap) state_d = STOP;
      end
      default: state_d = STOP;
    endcase

    // load_stb_q guards against re-accepting a request still held in its ready cycle.
    if (jam_ok && bus.jam_valid && !load_stb_q) begin
      load_stb_d  = 1'b1;
      frame_stb_d = 1'b0;
    end

    if (!frame_stb_d && !load_stb_d) begin
      if      (pend_q[HRS]) grant_d[HRS] = 1'b1;
      else if (pend_q[MIN]) grant_d[MIN] = 1'b1;
      else if (pend_q[SEC]) grant_d[SEC] = 1'b1;
    end

    pend_d = load_stb_d ? '0 : ((pend_q & ~grant_d) | bus.inc_req);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= STOP;
      rate_q      <= RATE_24;
      rate_err_q  <= 1'b0;
      half_idx_q  <= '0;
      half_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
      load_stb_q  <= 1'b0;
      pend_q      <= '0;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      rate_err_q  <= rate_err_d;
      half_idx_q  <= half_idx_d;
      half_stb_q  <= half_stb_d;
      frame_stb_q <= frame_stb_d;
      load_stb_q  <= load_stb_d;
      pend_q      <= pend_d;
      grant_q     <= grant_d;
    end
  end

`ifdef LTC_SCHED_FRAMECNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = ((state_q == ARM) ? 16'd0 : frame_cnt_q) + {15'd0, frame_stb_d};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign bus.jam_ready = load_stb_q;
  assign bus.load_stb  = load_stb_q;
  assign bus.frame_stb = frame_stb_q;
  assign bus.half_stb  = half_stb_q;
  assign bus.half_idx  = half_idx_q;
  assign bus.inc_grant = grant_q;
  assign running       = counting;
  assign rate_err      = rate_err_q;

endmodule

// File: tb/tb_ltc_sched.sv
// Directed bench for ltc_sched with shortened dividers (24/25/30 fps -> 8/6/4 clks per half-bit).
module tb_ltc_sched;

  logic       clk;
  logic       reset_n;
  logic [1:0] framerate;
  logic       run;
  logic       running;
  logic       rate_err;
`ifdef LTC_SCHED_FRAMECNT_EN
  logic [15:0] frame_cnt;
`endif

  ltc_sched_if bus ();

  ltc_sched #(.DIV_24(8), .DIV_25(6), .DIV_30(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .framerate (framerate),
    .run       (run),
    .bus       (bus),
    .running   (running),
    .rate_err  (rate_err)
`ifdef LTC_SCHED_FRAMECNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int frames_seen;

  localparam int W_FRAME = 0;
  localparam int W_HALF  = 1;
  localparam int W_JAM   = 2;
  localparam int W_IDLE  = 3;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Counts negedges until the selected event; n = -1 if the budget runs out.
  task automatic wait_for(input int which, input int budget, output int n);
    logic hit;
    n           = 0;
    hit         = 1'b0;
    frames_seen = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        W_FRAME: hit = bus.frame_stb;
        W_HALF:  hit = bus.half_stb;
        W_JAM:   hit = bus.jam_ready;
        default: hit = !running;
      endcase
      if (bus.frame_stb) frames_seen++;
    end
    if (!hit) n = -1;
  endtask

  int n, halves, frames, max_idx, strobes;

  initial begin
    reset_n       = 1'b0;
    run           = 1'b0;
    framerate     = 2'b01;
    bus.jam_valid = 1'b0;
    bus.inc_req   = 3'b000;

    repeat (3) @(negedge clk);
    check("rst_running",   int'(running), 0);
    check("rst_rate_err",  int'(rate_err), 0);
    check("rst_half_idx",  int'(bus.half_idx), 0);
    check("rst_strobes",   int'({bus.half_stb, bus.frame_stb, bus.load_stb, bus.jam_ready}), 0);
    check("rst_grant",     int'(bus.inc_grant), 0);

    // 25 fps: first frame on the first RUN cycle, 6-clk halves, 960-clk frames.
    reset_n = 1'b1;
    run     = 1'b1;
    wait_for(W_FRAME, 10, n);
    check("first_frame_lat", n, 2);
    check("first_frame_run", int'(running), 1);
    check("first_frame_idx", int'(bus.half_idx), 0);
`ifdef LTC_SCHED_FRAMECNT_EN
    check("frame_cnt_first", int'(frame_cnt), 1);
`endif
    wait_for(W_HALF, 20, n);
    check("half25_lat", n, 6);
    check("half25_idx", int'(bus.half_idx), 1);

    halves = 0; frames = 0; max_idx = 0;
    for (int i = 0; i < 954; i++) begin
      @(negedge clk);
      if (bus.half_stb) halves++;
      if (bus.frame_stb) frames++;
      if (int'(bus.half_idx) > max_idx) max_idx = int'(bus.half_idx);
    end
    check("frame25_end",    int'(bus.frame_stb), 1);
    check("frame25_count",  frames, 1);
    check("frame25_halves", halves, 159);
    check("frame25_maxidx", max_idx, 159);
    check("frame25_wrapidx", int'(bus.half_idx), 0);

    // Increments timed so the middle grant would land on the next frame_stb.
    repeat (957) @(negedge clk);
    bus.inc_req = 3'b111;
    @(negedge clk); bus.inc_req = 3'b000;
    check("incf_c0", int'(bus.inc_grant), 0);
    @(negedge clk); check("incf_hrs", int'(bus.inc_grant), 4);
    @(negedge clk); check("incf_blocked", int'(bus.inc_grant), 0);
    check("incf_frame", int'(bus.frame_stb), 1);
    @(negedge clk); check("incf_min", int'(bus.inc_grant), 2);
    @(negedge clk); check("incf_sec", int'(bus.inc_grant), 1);
    @(negedge clk); check("incf_idle", int'(bus.inc_grant), 0);

    // Mid-frame increments, with a repeated sec request merged while pending.
    repeat (10) @(negedge clk);
    bus.inc_req = 3'b111;
    @(negedge clk); bus.inc_req = 3'b001;
    check("inc_c0", int'(bus.inc_grant), 0);
    @(negedge clk); bus.inc_req = 3'b000;
    check("inc_hrs", int'(bus.inc_grant), 4);
    @(negedge clk); check("inc_min", int'(bus.inc_grant), 2);
    @(negedge clk); check("inc_sec", int'(bus.inc_grant), 1);
    @(negedge clk); check("inc_merged0", int'(bus.inc_grant), 0);
    @(negedge clk); check("inc_merged1", int'(bus.inc_grant), 0);

    // Rate change 25 -> 30 at offset 19: takes effect only after the next wrap.
    framerate = 2'b11;
    wait_for(W_FRAME, 2000, n);
    check("rate_chg_oldframe", n, 941);
    wait_for(W_HALF, 20, n);
    check("half30_lat", n, 4);
    wait_for(W_FRAME, 1000, n);
    check("frame30_len", n, 636);

    // Jam held from half_idx 40 is accepted on the wrap instead of frame_stb.
    repeat (160) @(negedge clk);
    check("jam_at_idx40", int'(bus.half_idx), 40);
    bus.jam_valid = 1'b1;
    wait_for(W_JAM, 1000, n);
    check("jam_lat",       n, 480);
    check("jam_load",      int'(bus.load_stb), 1);
    check("jam_no_frame",  int'(bus.frame_stb), 0);
    check("jam_half",      int'(bus.half_stb), 1);
    check("jam_idx",       int'(bus.half_idx), 0);
    check("jam_frames",    frames_seen, 0);
    bus.jam_valid = 1'b0;
    @(negedge clk);
    check("jam_ready_drop", int'({bus.jam_ready, bus.load_stb, bus.frame_stb}), 0);

    // Stop at half_idx 10: keeps running to the wrap, then STOP with no frame_stb.
    repeat (39) @(negedge clk);
    check("stop_at_idx10", int'(bus.half_idx), 10);
    run = 1'b0;
    @(negedge clk);
    check("stopping_running", int'(running), 1);
    wait_for(W_IDLE, 1000, n);
    check("stop_lat",      n, 599);
    check("stop_half",     int'(bus.half_stb), 1);
    check("stop_idx",      int'(bus.half_idx), 0);
    check("stop_no_frame", int'(bus.frame_stb), 0);
    check("stop_frames",   frames_seen, 0);
    repeat (5) @(negedge clk);
    check("stop_hold_idx",  int'(bus.half_idx), 0);
    check("stop_hold_half", int'(bus.half_stb), 0);

    // Jam and increment while stopped.
    bus.jam_valid = 1'b1;
    @(negedge clk);
    check("jam_stop_ready", int'(bus.jam_ready), 1);
    check("jam_stop_load",  int'(bus.load_stb), 1);
    bus.jam_valid = 1'b0;
    @(negedge clk);
    check("jam_stop_drop", int'(bus.jam_ready), 0);
    bus.inc_req = 3'b010;
    @(negedge clk); bus.inc_req = 3'b000;
    @(negedge clk);
    check("inc_stop_min", int'(bus.inc_grant), 2);

    // Invalid rate blocks ARM; switching to 24 fps starts with 8-clk halves.
    framerate = 2'b10;
    run       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bad_rate_err", int'(rate_err), 1);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.half_stb || bus.frame_stb || bus.load_stb) strobes++;
    end
    check("bad_no_strobes", strobes, 0);
    check("bad_not_running", int'(running), 0);
    framerate = 2'b00;
    @(negedge clk);
    check("arm_frame",     int'(bus.frame_stb), 1);
    check("arm_rate_ok",   int'(rate_err), 0);
    check("arm_running",   int'(running), 1);
`ifdef LTC_SCHED_FRAMECNT_EN
    check("frame_cnt_rearm", int'(frame_cnt), 1);
`endif
    wait_for(W_HALF, 30, n);
    check("half24_lat", n, 8);

    // Bad code at a wrap: flagged, old 24 fps rate kept.
    framerate = 2'b10;
    wait_for(W_FRAME, 3000, n);
    check("frame24_len", n, 1272);
    check("wrap_bad_err", int'(rate_err), 1);
    wait_for(W_FRAME, 3000, n);
    check("frame24_kept", n, 1280);

    // Reset mid-frame.
    repeat (50) @(negedge clk);
    check("pre_reset_idx_nz", int'(bus.half_idx != 8'd0), 1);
    reset_n = 1'b0;
    run     = 1'b0;
    @(negedge clk);
    check("mid_rst_running", int'(running), 0);
    check("mid_rst_idx",     int'(bus.half_idx), 0);
    check("mid_rst_strobes", int'({bus.half_stb, bus.frame_stb, bus.load_stb}), 0);
    check("mid_rst_err",     int'(rate_err), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_running", int'(running), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
